// File: rtl/vram_slot_arbiter.sv
// rtl/vram_slot_arbiter.sv - two-slot VRAM time-share between video fetch and a CPU port
//
// Purpose:
//   An 8-cycle frame is split into two launch slots on a free-running 3-bit
//   phase counter. The launch edge leaving phase 7 belongs to video while the
//   display window is open and to the CPU while blanked. The launch edge
//   leaving phase 3 always belongs to the CPU. Only one access is ever in
//   flight. A launch edge that arrives while an access is in flight is
//   skipped. A rising h_synch realigns the phase to 0.
//
// Ports:
//   pixel_clock       clock; all state changes on its rising edge
//   reset_n           asynchronous active-low reset
//   h_synch           horizontal sync; its rising edge forces phase 0
//   video_active      display fetch window open (phase-7 slot owned by video)
//   video_addr        address of the next video fetch
//   cpu_req/we/addr/wdata  level request, held until cpu_ack
//   vram_addr/we/wdata     synchronous VRAM port, 1-cycle read latency
//   vram_rdata        VRAM read data
//   cpu_rdata         read data returned to the CPU
//   cpu_ack           1-cycle completion pulse
//   cpu_wait          cpu_req & ~cpu_ack
//   video_data        last fetched video byte
//   video_data_valid  1-cycle pulse when video_data is refreshed

module vram_slot_arbiter (
  input  logic        pixel_clock,
  input  logic        reset_n,
  input  logic        h_synch,
  input  logic        video_active,
  input  logic [12:0] video_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [12:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_wait,
  output logic [7:0]  video_data,
  output logic        video_data_valid
);

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ACCESS,
    CAPTURE,
    ACK
  } cpu_state_t;

  cpu_state_t cpu_state;

  logic [2:0] phase;
  logic       h_synch_d;
  logic [1:0] vid_pipe;
  logic       access_is_write;
  logic       ack_holdoff;

  logic h_rise;
  logic video_slot_edge;
  logic cpu_slot_edge;
  logic in_flight;
  logic launch_video;
  logic launch_cpu;

  assign h_rise          = h_synch & ~h_synch_d;
  assign video_slot_edge = (phase == 3'd7);
  assign cpu_slot_edge   = (phase == 3'd3);

  // The CPU side counts as busy from launch until it has returned to IDLE, so
  // the slot right after an ack can never overlap the acknowledged access.
  assign in_flight = (vid_pipe != 2'b00) ||
                     (cpu_state == ACCESS) ||
                     (cpu_state == CAPTURE) ||
                     (cpu_state == ACK);

  assign launch_video = video_slot_edge & video_active & ~in_flight;

  // The phase-7 slot falls to the CPU only while the display window is closed.
  // When video owns the slot but it is skipped, the CPU does not inherit it.
  assign launch_cpu = (cpu_state == PEND) & ~in_flight &
                      (cpu_slot_edge | (video_slot_edge & ~video_active));

  assign cpu_wait = cpu_req & ~cpu_ack;

  // Phase counter with h_synch realignment.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= 3'd0;
      h_synch_d <= 1'b0;
    end else begin
      h_synch_d <= h_synch;
      if (h_rise) begin
        phase <= 3'd0;
      end else begin
        phase <= phase + 3'd1;
      end
    end
  end

  // Video fetch pipeline. vid_pipe[0] marks the cycle the address is on the
  // VRAM port and vid_pipe[1] the cycle the read data comes back.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      vid_pipe         <= 2'b00;
      video_data       <= 8'h00;
      video_data_valid <= 1'b0;
    end else begin
      vid_pipe         <= {vid_pipe[0], launch_video};
      video_data_valid <= vid_pipe[1];
      if (vid_pipe[1]) begin
        video_data <= vram_rdata;
      end
    end
  end

  // CPU FSM and the shared VRAM port registers. Progress after launch is
  // driven by the state alone, so an h_synch realignment mid-access is harmless.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_state       <= IDLE;
      vram_addr       <= 13'd0;
      vram_we         <= 1'b0;
      vram_wdata      <= 8'h00;
      cpu_rdata       <= 8'h00;
      cpu_ack         <= 1'b0;
      access_is_write <= 1'b0;
      ack_holdoff     <= 1'b0;
    end else begin
      vram_we <= 1'b0;
      cpu_ack <= 1'b0;

      if (launch_video) begin
        vram_addr <= video_addr;
      end

      case (cpu_state)
        IDLE: begin
          // The requester is still dropping cpu_req during the first IDLE
          // cycle after an ack, so that cycle is ignored.
          if (ack_holdoff) begin
            ack_holdoff <= 1'b0;
          end else if (cpu_req && !cpu_ack) begin
            cpu_state <= PEND;
          end
        end
        PEND: begin
          if (launch_cpu) begin
            cpu_state       <= ACCESS;
            vram_addr       <= cpu_addr;
            vram_wdata      <= cpu_wdata;
            vram_we         <= cpu_we;
            access_is_write <= cpu_we;
          end
        end
        ACCESS: begin
          cpu_state <= CAPTURE;
        end
        CAPTURE: begin
          if (!access_is_write) begin
            cpu_rdata <= vram_rdata;
          end
          cpu_ack   <= 1'b1;
          cpu_state <= ACK;
        end
        ACK: begin
          ack_holdoff <= 1'b1;
          cpu_state   <= IDLE;
        end
        default: begin
          cpu_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb/tb_vram_slot_arbiter.sv - self-checking bench for vram_slot_arbiter

module tb_vram_slot_arbiter;

  logic        pixel_clock = 1'b0;
  logic        reset_n;
  logic        h_synch;
  logic        video_active;
  logic [12:0] video_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [7:0]  video_data;
  logic        video_data_valid;

  always #5 pixel_clock = ~pixel_clock;

  vram_slot_arbiter dut (
    .pixel_clock      (pixel_clock),
    .reset_n          (reset_n),
    .h_synch          (h_synch),
    .video_active     (video_active),
    .video_addr       (video_addr),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .vram_addr        (vram_addr),
    .vram_we          (vram_we),
    .vram_wdata       (vram_wdata),
    .vram_rdata       (vram_rdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_ack          (cpu_ack),
    .cpu_wait         (cpu_wait),
    .video_data       (video_data),
    .video_data_valid (video_data_valid)
  );

  int vectors = 0;
  int miscompares = 0;

  // Synchronous VRAM with a preset port used only while the DUT is in reset.
  logic [7:0]  mem [0:8191];
  logic        preset_en = 1'b0;
  logic [12:0] preset_addr = 13'd0;
  logic [7:0]  preset_data = 8'h00;

  always @(posedge pixel_clock) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    else if (preset_en) mem[preset_addr] <= preset_data;
    vram_rdata <= mem[vram_addr];
  end

  // Edges since reset release; with no realignment the phase before edge n is (n-1)%8.
  int cyc;
  always @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(negedge pixel_clock);
  endtask

  task automatic preset(input logic [12:0] a, input logic [7:0] d);
    preset_en = 1'b1; preset_addr = a; preset_data = d;
    tick;
    preset_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vram_addr"}, vram_addr, 0);
    check({tag, "_vram_we"}, vram_we, 0);
    check({tag, "_vram_wdata"}, vram_wdata, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_cpu_ack"}, cpu_ack, 0);
    check({tag, "_video_data"}, video_data, 0);
    check({tag, "_video_valid"}, video_data_valid, 0);
  endtask

  task automatic cpu_xfer(input bit we, input logic [12:0] a, input logic [7:0] wd, output int ack_cyc);
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    ack_cyc = -1;
    for (int k = 0; k < 24; k++) begin
      tick;
      if (cpu_ack) begin
        ack_cyc = cyc;
        break;
      end
      check("cpu_wait_high", cpu_wait, 1);
    end
    if (ack_cyc < 0) begin
      vectors++; miscompares++;
      $display("FAIL cpu_ack_timeout: got no ack, expected one within 24 cycles");
    end else begin
      check("cpu_wait_low_at_ack", cpu_wait, 0);
    end
    cpu_req = 1'b0;
  endtask

  // Phase monitor used while the frame is aligned and video reads 0x0123.
  bit mon_en = 1'b0;
  always @(negedge pixel_clock) begin
    if (mon_en && reset_n) begin
      if (vram_we) check("we_phase", cyc % 8, 4);
      if (video_data_valid) begin
        check("vid_phase", cyc % 8, 2);
        check("vid_data_during_cpu", video_data, 8'h5A);
      end
    end
  end

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
  } vid_vec_t;

  typedef struct {
    bit          we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } cpu_vec_t;

  vid_vec_t vt [4];
  cpu_vec_t ct [5];

  // Reference model state for the random run.
  logic [7:0] ref_mem [0:8191];
  int  m, ph, free_edge, accept_edge, vid_edge, ack_edge;
  bit  hs_prev, pending, ack_read;
  logic [7:0]  vid_val, ack_val;
  logic [12:0] exp_addr;
  logic [7:0]  exp_vd, exp_rd;
  bit  exp_we, exp_vv, exp_ack;

  initial begin
    int ack_c, prev_ack, raise_c, found, idle_gap;

    vt[0] = '{13'h0200, 8'h77};
    vt[1] = '{13'h0300, 8'h99};
    vt[2] = '{13'h0040, 8'h3C};
    vt[3] = '{13'h0123, 8'h5A};

    ct[0] = '{1'b1, 13'h1F00, 8'hA5, 8'h00};
    ct[1] = '{1'b0, 13'h1F00, 8'h00, 8'hA5};
    ct[2] = '{1'b0, 13'h0040, 8'h00, 8'h3C};
    ct[3] = '{1'b1, 13'h0040, 8'hC3, 8'h3C};
    ct[4] = '{1'b0, 13'h0040, 8'h00, 8'hC3};

    reset_n = 1'b0; h_synch = 1'b0; video_active = 1'b1; video_addr = 13'h0123;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'd0; cpu_wdata = 8'h00;
    tick;
    preset(13'h0123, 8'h5A);
    preset(13'h0040, 8'h3C);
    preset(13'h1F00, 8'h11);
    preset(13'h0200, 8'h77);
    preset(13'h0300, 8'h99);
    check_reset_outputs("reset");

    // First launch is the phase-7 slot, 8 edges after release.
    reset_n = 1'b1;
    repeat (7) tick;
    check("first_launch_not_early", vram_addr, 0);
    tick;
    check("first_launch_addr", vram_addr, 13'h0123);
    tick;
    check("fetch_no_early_valid", video_data_valid, 0);
    tick;
    check("fetch_valid", video_data_valid, 1);
    check("fetch_data", video_data, 8'h5A);
    tick;
    check("fetch_valid_one_cycle", video_data_valid, 0);

    for (int i = 0; i < 4; i++) begin
      video_addr = vt[i].addr;
      found = 0;
      for (int k = 0; k < 12 && found == 0; k++) begin
        tick;
        if (video_data_valid) found = 1;
      end
      check("vid_tbl_found", found, 1);
      check("vid_tbl_data", video_data, vt[i].data);
      check("vid_tbl_phase", cyc % 8, 2);
    end

    video_addr = 13'h0123;
    repeat (4) tick;
    mon_en = 1'b1;
    prev_ack = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      cpu_xfer(ct[i].we, ct[i].addr, ct[i].wdata, ack_c);
      check("cpu_tbl_rdata", cpu_rdata, ct[i].exp_rdata);
      check("cpu_tbl_ack_phase", ack_c % 8, 6);
      if (ct[i].we) check("cpu_tbl_mem", mem[ct[i].addr], ct[i].wdata);
      if (i > 0) check("cpu_b2b_ack_spacing", ack_c - prev_ack, 8);
      prev_ack = ack_c;
      tick;
      check("cpu_ack_one_cycle", cpu_ack, 0);
    end
    mon_en = 1'b0;

    // Blanked read requested in phase 6 launches on the phase-7 edge.
    video_active = 1'b0;
    for (int k = 0; k < 8 && (cyc % 8) != 6; k++) tick;
    raise_c = cyc;
    cpu_xfer(1'b0, 13'h0040, 8'h00, ack_c);
    check("blank_ack_latency", ack_c - raise_c, 4);
    check("blank_rdata", cpu_rdata, 8'hC3);

    // h_synch rises while the read is in ACCESS.
    video_active = 1'b1;
    tick;
    for (int k = 0; k < 8 && (cyc % 8) != 2; k++) tick;
    cpu_we = 1'b0; cpu_addr = 13'h1F00; cpu_req = 1'b1;
    tick;
    tick;
    h_synch = 1'b1;
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      tick;
      if (cpu_ack) found = 1;
    end
    check("realign_ack_found", found, 1);
    check("realign_ack_phase", cyc % 8, 6);
    check("realign_rdata", cpu_rdata, 8'hA5);
    cpu_req = 1'b0;
    tick;
    h_synch = 1'b0;
    found = 0;
    for (int k = 0; k < 16 && found == 0; k++) begin
      tick;
      if (video_data_valid) found = 1;
    end
    check("realign_vid_found", found, 1);
    check("realign_vid_phase", cyc % 8, 7);

    // Reset asserted while a write is in ACCESS.
    cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'hEE; cpu_req = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick;
      if (vram_we) found = 1;
    end
    check("rst_write_started", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_we_dropped", vram_we, 0);
    check("rst_no_ack", cpu_ack, 0);
    check_reset_outputs("midreset");
    cpu_req = 1'b0;
    tick;
    tick;
    check("rst_write_discarded", mem[13'h0200], 8'h77);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      check("rst_no_ack_after", cpu_ack, 0);
      if (k == 7) check("rst_relaunch_not_early", vram_addr, 0);
    end
    check("rst_relaunch_addr", vram_addr, 13'h0123);

    // Random run against the slot-schedule model.
    reset_n = 1'b0; h_synch = 1'b0; cpu_req = 1'b0; video_active = 1'b1;
    repeat (3) tick;
    for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];
    m = 0; ph = 0; hs_prev = 0; free_edge = 0; accept_edge = 0;
    vid_edge = -1; ack_edge = -1; pending = 0; ack_read = 0;
    vid_val = 0; ack_val = 0;
    exp_addr = 0; exp_vd = 0; exp_rd = 0; exp_we = 0; exp_vv = 0; exp_ack = 0;
    idle_gap = 0;
    reset_n = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      check("rnd_vram_addr", vram_addr, exp_addr);
      check("rnd_vram_we", vram_we, exp_we);
      check("rnd_video_valid", video_data_valid, exp_vv);
      check("rnd_video_data", video_data, exp_vd);
      check("rnd_cpu_ack", cpu_ack, exp_ack);
      check("rnd_cpu_rdata", cpu_rdata, exp_rd);
      check("rnd_cpu_wait", cpu_wait, cpu_req & ~exp_ack);

      if (exp_ack) begin
        cpu_req = 1'b0;
        idle_gap = $urandom_range(0, 3);
      end else if (!cpu_req) begin
        if (idle_gap > 0) idle_gap--;
        else if ($urandom % 3 == 0) begin
          cpu_req = 1'b1;
          cpu_we = $urandom % 2;
          cpu_addr = 13'($urandom_range(0, 15));
          cpu_wdata = 8'($urandom);
        end
      end
      if ($urandom % 20 == 0) video_active = ~video_active;
      video_addr = 13'($urandom_range(0, 15));
      h_synch = ($urandom % 50 == 0);

      // Model: what the next edge does, given the slot rules.
      m++;
      exp_we = 0; exp_vv = 0; exp_ack = 0;
      if (m >= free_edge && ph == 7 && video_active) begin
        vid_edge = m + 2;
        vid_val = ref_mem[video_addr];
        exp_addr = video_addr;
        free_edge = m + 3;
      end else if (m >= free_edge && pending && (ph == 3 || (ph == 7 && !video_active))) begin
        exp_addr = cpu_addr;
        exp_we = cpu_we;
        ack_read = !cpu_we;
        ack_val = ref_mem[cpu_addr];
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        ack_edge = m + 2;
        free_edge = m + 4;
        accept_edge = m + 5;
        pending = 0;
      end
      if (m == vid_edge) begin
        exp_vv = 1;
        exp_vd = vid_val;
      end
      if (m == ack_edge) begin
        exp_ack = 1;
        if (ack_read) exp_rd = ack_val;
      end
      if (!pending && m >= accept_edge && cpu_req) pending = 1;
      if (h_synch && !hs_prev) ph = 0;
      else ph = (ph + 1) % 8;
      hs_prev = h_synch;

      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
